// File: rtl/spi_pkg.sv
// Shared SPI types: controller state encoding and clock-mode constants.
// Only mode 0 is implemented; CPOL/CPHA are held here for future modes.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOW   = 2'd1,
    HIGH  = 2'd2,
    TRAIL = 2'd3
  } state_t;

  localparam bit CPOL = 1'b0;
  localparam bit CPHA = 1'b0;

endpackage

// File: rtl/spi_sck_gen.sv
// SCK half-period divider: tick is a combinational pulse on the last of every CLK_DIV enabled cycles.
// Latency: first tick CLK_DIV cycles after clear; no backpressure, clr wins over en.
module spi_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_controller.sv
// Mode-0 SPI initiator, MSB first, one WIDTH-bit word per start request; all outputs registered.
// Latency: done (2*WIDTH+1)*CLK_DIV cycles after start is accepted; start ignored while busy.
module spi_controller
  import spi_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic             sck,
  output logic             mosi,
  input  logic             miso,
  output logic             cs_n
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tx_q, tx_d, tx_shift;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             busy_d, done_d, sck_d, mosi_d, cs_n_d;
  logic [WIDTH-1:0] data_out_d;
  logic             tick, div_clr, div_en;

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (div_clr),
    .en   (div_en),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      tx_q     <= '0;
      rx_q     <= '0;
      bit_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= 1'b1;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      bit_q    <= bit_d;
      busy     <= busy_d;
      done     <= done_d;
      data_out <= data_out_d;
      sck      <= sck_d;
      mosi     <= mosi_d;
      cs_n     <= cs_n_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    bit_d      = bit_q;
    busy_d     = busy;
    done_d     = 1'b0;
    data_out_d = data_out;
    sck_d      = sck;
    mosi_d     = mosi;
    cs_n_d     = cs_n;
    div_clr    = (state_q == IDLE);
    div_en     = (state_q != IDLE);
    // Shifting via << keeps WIDTH=1 free of zero-width slices.
    tx_shift   = tx_q << 1;

    case (state_q)
      IDLE: begin
        cs_n_d = 1'b1;
        sck_d  = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          tx_d    = data_in;
          mosi_d  = data_in[WIDTH-1];
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          bit_d   = '0;
          state_d = LOW;
        end
      end
      LOW: begin
        if (tick) begin
          sck_d   = 1'b1;
          rx_d    = (rx_q << 1) | WIDTH'(miso);
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (tick) begin
          sck_d = 1'b0;
          if (bit_q == BW'(WIDTH - 1)) begin
            state_d = TRAIL;
          end else begin
            tx_d    = tx_shift;
            mosi_d  = tx_shift[WIDTH-1];
            bit_d   = bit_q + BW'(1);
            state_d = LOW;
          end
        end
      end
      TRAIL: begin
        if (tick) begin
          cs_n_d     = 1'b1;
          mosi_d     = 1'b0;
          data_out_d = rx_q;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboarded bench: directed and random SPI words against a transaction-level model.
module tb_spi_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       busy, done, sck, mosi, miso, cs_n;
  logic [7:0] data_out;

  logic       start1 = 1'b0;
  logic [0:0] din1 = 1'b0;
  logic       busy1, done1, sck1, mosi1, cs_n1;
  logic [0:0] dout1;

  always #5 clk = ~clk;

  spi_controller #(.WIDTH(8), .CLK_DIV(4)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .busy(busy), .done(done),
    .data_out(data_out), .sck(sck), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  spi_controller #(.WIDTH(1), .CLK_DIV(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .data_in(din1), .busy(busy1), .done(done1),
    .data_out(dout1), .sck(sck1), .mosi(mosi1), .miso(1'b1), .cs_n(cs_n1)
  );

  typedef struct {
    logic [7:0] data;
    logic [7:0] mosi_w;
    int         done_cyc;
    int         gap;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;

  // Responder: loopback, or a shift register advancing on each SCK fall.
  bit         loop = 1'b1;
  logic [7:0] resp_word = 8'h00;
  int         idx = 0;
  assign miso = loop ? mosi : resp_word[3'(7 - idx)];

  int         rises, lowcnt, highcnt, gap_seen;
  logic [7:0] mw;
  logic       prev_sck, prev_cs;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (q.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("pending_done_timeout", q.size(), 0);
    q.delete();
  endtask

  task automatic issue(input logic [7:0] d, input bit lb, input logic [7:0] rw,
                       input int gap_exp, output int t);
    exp_t e;
    @(negedge clk);
    loop      = lb;
    resp_word = rw;
    data_in   = d;
    start     = 1'b1;
    t         = cyc + 1;
    e.data    = lb ? d : rw;
    e.mosi_w  = d;
    e.done_cyc = t + 68;
    e.gap     = gap_exp;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic monitor_step();
    exp_t e;
    if (!rst) begin
      rises = 0; mw = 8'h00; lowcnt = 0; highcnt = 0; gap_seen = -1;
      idx = 0; prev_sck = 1'b0; prev_cs = 1'b1;
      return;
    end
    if (done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        check("data_out", data_out, e.data);
        check("done_cycle", cyc, e.done_cyc);
        check("mosi_bits", mw, e.mosi_w);
        check("sck_rises", rises, 8);
        check("cs_low_cycles", lowcnt, 68);
        check("busy_at_done", busy, 0);
        if (e.gap >= 0) check("cs_gap", gap_seen, e.gap);
      end
      rises = 0; mw = 8'h00; lowcnt = 0;
    end
    if (!cs_n) begin
      if (prev_cs) begin
        gap_seen = highcnt;
        highcnt  = 0;
      end
      lowcnt++;
    end else begin
      highcnt++;
    end
    if (sck && !prev_sck) begin
      rises++;
      mw = {mw[6:0], mosi};
    end
    if (cs_n) idx = 0;
    else if (!sck && prev_sck) idx++;
    prev_sck = sck;
    prev_cs  = cs_n;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before %0t", $time);
    $fatal(1);
  end

  initial begin
    int t, k, t1;
    bit seen;
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n, 1);
    check("rst_sck", sck, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data_out", data_out, 0);
    check("rst_w1_cs_n", {cs_n1, sck1, mosi1, busy1}, 4'b1000);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback 0xA5
    issue(8'hA5, 1'b1, 8'h00, -1, t);
    wait_idle();

    // Responder returns 0x3C while 0xC3 is sent
    issue(8'hC3, 1'b0, 8'h3C, -1, t);
    wait_idle();

    // Starts during a transfer are ignored; data_in changes after capture
    issue(8'hA5, 1'b1, 8'h00, -1, t);
    data_in = 8'h0F;
    wait_cyc(t + 4);
    start = 1'b1; data_in = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(t + 39);
    start = 1'b1; data_in = 8'h00;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (80) @(negedge clk);

    // Reset mid-transaction, then a fresh transfer
    issue(8'hC3, 1'b1, 8'h00, -1, t);
    wait_cyc(t + 30);
    #1 rst = 1'b0;
    #1;
    check("arst_cs_n", cs_n, 1);
    check("arst_sck", sck, 0);
    check("arst_busy", busy, 0);
    check("arst_data_out", data_out, 0);
    check("arst_done", done, 0);
    q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    issue(8'h5A, 1'b1, 8'h00, -1, t);
    wait_idle();

    // Back-to-back with start held high
    @(negedge clk);
    loop = 1'b1;
    data_in = 8'h12;
    start = 1'b1;
    t = cyc + 1;
    q.push_back('{data: 8'h12, mosi_w: 8'h12, done_cyc: t + 68, gap: -1});
    q.push_back('{data: 8'h34, mosi_w: 8'h34, done_cyc: t + 137, gap: 1});
    @(negedge clk);
    data_in = 8'h34;
    wait_cyc(t + 69);
    start = 1'b0;
    wait_idle();

    // Random words, random responder mode and idle gaps
    for (int i = 0; i < 12; i++) begin
      issue(8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), -1, t);
      wait_idle();
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end

    // WIDTH=1, CLK_DIV=2, miso tied high
    @(negedge clk);
    start1 = 1'b1;
    din1 = 1'b0;
    t1 = cyc + 1;
    @(negedge clk);
    start1 = 1'b0;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 40) begin
      if (done1) begin
        seen = 1'b1;
        check("w1_done_cycle", cyc, t1 + 6);
        check("w1_data_out", dout1, 1);
      end else begin
        @(negedge clk);
        k++;
      end
    end
    check("w1_done_seen", seen, 1);

    repeat (20) @(negedge clk);
    check("leftover_expectations", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
